// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt controller with claim/complete handshake for the CPU
// Ports: clk/reset (sync, active-high); src interrupt lines; select/rd/wr/addr/data_in/data_out
// CPU bus slave (0 PENDING, 1 ENABLE, 2 CAUSE, 3 SOFT); interrupt = request to CPU (state REQ).
module irq_controller #(
  parameter int NUM_SRC = 8,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               select,
  input  logic               rd,
  input  logic [3:0]         wr,
  input  logic [1:0]         addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               interrupt
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_d;
  logic [NUM_SRC-1:0] src_q, latch, enable, lane, pending, active, pend_clr, soft_set, en_mask, claim_mask;
  logic [IDW-1:0] claimed_id, best, cause_id;
  logic claim, complete, valid, unused_ok;
  logic [31:0] cause;
  assign unused_ok = ^{data_in, wr};
  always_comb begin
    lane = '0;
    for (int i = 0; i < NUM_SRC; i++) lane[i] = wr[i/8];
  end
  always_comb begin
    best = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (active[i]) best = IDW'(i);
  end
  assign pending    = latch | (src_q & ~EDGE_MASK);
  assign active     = pending & enable;
  assign pend_clr   = (select && addr == 2'd0) ? data_in[NUM_SRC-1:0] & lane : '0;
  assign soft_set   = (select && addr == 2'd3) ? data_in[NUM_SRC-1:0] & lane : '0;
  assign en_mask    = (select && addr == 2'd1) ? lane : '0;
  // a claim only happens while something is still active, so best is meaningful
  assign claim      = state == REQ && |active && select && rd && addr == 2'd2;
  assign claim_mask = claim ? NUM_SRC'(1) << best : '0;
  assign complete   = state == SERVICE && select && wr[0] && addr == 2'd2 && data_in[IDW-1:0] == claimed_id;
  assign valid      = (state == REQ && |active) || state == SERVICE;
  assign cause_id   = state == SERVICE ? claimed_id : best;
  assign cause      = valid ? {1'b1, 26'b0, 5'(cause_id)} : '0;
  assign data_out   = addr == 2'd0 ? 32'(pending) :
                      addr == 2'd1 ? 32'(enable) :
                      addr == 2'd2 ? cause : '0;
  assign interrupt  = state == REQ;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = |active ? REQ : IDLE;
      REQ:     state_d = !(|active) ? IDLE : claim ? SERVICE : REQ;
      SERVICE: state_d = complete ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      src_q      <= '0;
      latch      <= '0;
      enable     <= '0;
      claimed_id <= '0;
    end else begin
      state      <= state_d;
      src_q      <= src;
      // set terms come last so a new event survives a same-cycle clear
      latch      <= (latch & ~pend_clr & ~claim_mask) | (EDGE_MASK & src & ~src_q) | soft_set;
      enable     <= (enable & ~en_mask) | (data_in[NUM_SRC-1:0] & en_mask);
      if (claim) claimed_id <= best;
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scoreboard bench for irq_controller
module tb_irq_controller;
  logic clk = 0, reset = 1, select = 0, rd = 0;
  logic [7:0] src = '0;
  logic [3:0] wr = '0;
  logic [1:0] addr = '0;
  logic [31:0] data_in = '0, data_out;
  logic interrupt;
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  irq_controller #(.NUM_SRC(8), .EDGE_MASK(8'h76)) dut (
    .clk(clk), .reset(reset), .src(src), .select(select), .rd(rd), .wr(wr),
    .addr(addr), .data_in(data_in), .data_out(data_out), .interrupt(interrupt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    select = 1; rd = 1; addr = a;
    @(negedge clk);
    d = data_out;
    tick();
    select = 0; rd = 0;
    check(tag_q.pop_front(), d, exp_q.pop_front());
  endtask
  task automatic irq_chk(input string tag, input logic exp);
    exp_q.push_back({31'b0, exp});
    tag_q.push_back(tag);
    check(tag_q.pop_front(), {31'b0, interrupt}, exp_q.pop_front());
  endtask
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] v, input logic [3:0] w);
    select = 1; wr = w; addr = a; data_in = v;
    tick();
    select = 0; wr = '0; data_in = '0;
  endtask
  task automatic pulse(input logic [7:0] s);
    src = s;
    tick();
    src = '0;
  endtask
  initial begin
    repeat (3) tick();
    reset = 0;
    irq_chk("t1_irq", 0);
    rd_chk("t1_enable", 2'd1, 0);
    rd_chk("t1_pending", 2'd0, 0);
    rd_chk("t1_cause", 2'd2, 0);
    bus_wr(2'd1, 32'h04, 4'b0001);
    pulse(8'h04);
    irq_chk("t2_irq_n", 0);
    tick();
    irq_chk("t2_irq_n1", 1);
    rd_chk("t2_claim", 2'd2, 32'h8000_0002);
    irq_chk("t2_irq_svc", 0);
    rd_chk("t2_pending", 2'd0, 0);
    bus_wr(2'd2, 32'd2, 4'b0001);
    tick();
    irq_chk("t2_irq_done", 0);
    rd_chk("t2_cause_idle", 2'd2, 0);
    bus_wr(2'd1, 32'hFF, 4'b0001);
    pulse(8'h22);
    tick();
    irq_chk("t3_irq", 1);
    rd_chk("t3_claim1", 2'd2, 32'h8000_0001);
    bus_wr(2'd2, 32'd1, 4'b0001);
    irq_chk("t3_irq_idle", 0);
    tick();
    irq_chk("t3_irq_again", 1);
    rd_chk("t3_claim5", 2'd2, 32'h8000_0005);
    bus_wr(2'd2, 32'd5, 4'b0001);
    tick();
    irq_chk("t3_irq_done", 0);
    bus_wr(2'd1, 32'h01, 4'b0001);
    src = 8'h01;
    tick();
    tick();
    irq_chk("t4_irq", 1);
    src = '0;
    tick();
    tick();
    irq_chk("t4_irq_drop", 0);
    rd_chk("t4_cause", 2'd2, 0);
    bus_wr(2'd1, 32'hFF, 4'b0001);
    pulse(8'h04);
    tick();
    rd_chk("t5_claim2", 2'd2, 32'h8000_0002);
    pulse(8'h10);
    tick();
    irq_chk("t5_irq_svc", 0);
    bus_wr(2'd2, 32'd3, 4'b0001);
    tick();
    irq_chk("t5_irq_wrongid", 0);
    rd_chk("t5_cause_svc", 2'd2, 32'h8000_0002);
    bus_wr(2'd2, 32'd2, 4'b0001);
    tick();
    irq_chk("t5_irq_next", 1);
    rd_chk("t5_claim4", 2'd2, 32'h8000_0004);
    src = 8'h40;
    bus_wr(2'd0, 32'h40, 4'b0001);
    src = '0;
    rd_chk("t6_pending6", 2'd0, 32'h40);
    reset = 1;
    tick();
    reset = 0;
    irq_chk("t6_irq_rst", 0);
    rd_chk("t6_pending_rst", 2'd0, 0);
    rd_chk("t6_enable_rst", 2'd1, 0);
    rd_chk("t6_cause_rst", 2'd2, 0);
    irq_chk("t6_irq_idle", 0);
    bus_wr(2'd1, 32'h08, 4'b0001);
    bus_wr(2'd3, 32'h08, 4'b0001);
    rd_chk("soft_pending", 2'd0, 32'h08);
    irq_chk("soft_irq", 1);
    rd_chk("soft_read0", 2'd3, 0);
    rd_chk("soft_claim", 2'd2, 32'h8000_0003);
    rd_chk("soft_pending_clr", 2'd0, 0);
    bus_wr(2'd1, 32'h0000_0100, 4'b0010);
    rd_chk("lane_enable", 2'd1, 32'h08);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
